conv_compute_filter_mc: RTL

Parametrised, multi-channel successor to the single-window conv filter. It computes one output feature-map pixel per frame: sum over NUM_CHANNELS of (FILTER_ROWS x FILTER_ROWS signed dot product), plus bias, then optional ReLU and saturation. The engine accepts one channel window per beat through a 3-stage pipeline (multiply, adder tree, channel accumulate/output). It sits between the window-extraction/weight-fetch logic and the pooling layer, with valid/ready on both sides.

---
 rtl/conv_compute_filter_mc.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/conv_compute_filter_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_compute_filter_mc : multi-channel K x K signed conv engine (bias/ReLU/sat)
// Rev 1.0
// ---------------------------------------------------------------------------
module conv_compute_filter_mc #(
  parameter int FILTER_ROWS  = 5,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int NUM_CHANNELS = 6,
  parameter int OUTPUT_WIDTH = 16,
  parameter int RELU_EN      = 1,
  localparam int KK          = FILTER_ROWS * FILTER_ROWS,
  localparam int ACC_WIDTH   = PIXEL_WIDTH + WEIGHT_WIDTH + $clog2(KK) + $clog2(NUM_CHANNELS) + 1,
  localparam int CNT_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                 conv_filt_clk,
  input  logic                                 conv_filt_rst,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [KK-1:0][PIXEL_WIDTH-1:0]       pxl_filt_vals_i,
  input  logic [KK-1:0][WEIGHT_WIDTH-1:0]      weight_vals_i,
  input  logic [ACC_WIDTH-1:0]                 bias_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [OUTPUT_WIDTH-1:0]              conv_compute_filter_o,
  output logic                                 sat_o,
  output logic [CNT_WIDTH-1:0]                 chan_cnt_o
);

  localparam int PW = PIXEL_WIDTH + WEIGHT_WIDTH;

  logic stall, accept, first_beat, last_beat;

  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall;
  assign accept     = in_valid_i & in_ready_o;
  assign first_beat = (chan_cnt_o == '0);
  assign last_beat  = (chan_cnt_o == CNT_WIDTH'(NUM_CHANNELS - 1));

  logic signed [PW-1:0] prod_c [KK];

  for (genvar i = 0; i < KK; i++) begin : g_mult
    assign prod_c[i] = PW'($signed(pxl_filt_vals_i[i])) * PW'($signed(weight_vals_i[i]));
  end

  // Stage 1: products, tags, bias (bias travels with the beat so frames never mix)
  logic                 s1_valid, s1_first, s1_last;
  logic signed [PW-1:0] s1_prod [KK];
  logic [ACC_WIDTH-1:0] s1_bias;

  always_ff @(posedge conv_filt_clk) begin
    if (conv_filt_rst) begin
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_bias    <= '0;
      chan_cnt_o <= '0;
      for (int i = 0; i < KK; i++) s1_prod[i] <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= first_beat;
        s1_last  <= last_beat;
        for (int i = 0; i < KK; i++) s1_prod[i] <= prod_c[i];
        if (first_beat) s1_bias <= bias_i;
        chan_cnt_o <= last_beat ? '0 : chan_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

  // Stage 2: adder tree over sign-extended products
  logic signed [ACC_WIDTH-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < KK; i++) sum_c = sum_c + ACC_WIDTH'(s1_prod[i]);
  end

  logic                        s2_valid, s2_first, s2_last;
  logic signed [ACC_WIDTH-1:0] s2_sum;
  logic [ACC_WIDTH-1:0]        s2_bias;

  always_ff @(posedge conv_filt_clk) begin
    if (conv_filt_rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
      s2_bias  <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_sum   <= sum_c;
        s2_bias  <= s1_bias;
      end
    end
  end

  // Stage 3: channel accumulation
  logic signed [ACC_WIDTH-1:0] acc, s3_res, nxt_c;
  logic                        s3_valid;

  assign nxt_c = (s2_first ? $signed(s2_bias) : acc) + s2_sum;

  always_ff @(posedge conv_filt_clk) begin
    if (conv_filt_rst) begin
      acc      <= '0;
      s3_res   <= '0;
      s3_valid <= 1'b0;
    end else if (!stall) begin
      s3_valid <= s2_valid & s2_last;
      if (s2_valid) begin
        acc    <= nxt_c;
        s3_res <= nxt_c;
      end
    end
  end

  // Output: ReLU, then saturate when the upper bits are not a pure sign extension
  logic signed [ACC_WIDTH-1:0]          relu_c;
  logic [ACC_WIDTH-OUTPUT_WIDTH:0]      upper_c;
  logic                                 fits_c;
  logic [OUTPUT_WIDTH-1:0]              sat_val_c;

  always_comb begin
    relu_c    = ((RELU_EN != 0) && s3_res[ACC_WIDTH-1]) ? '0 : s3_res;
    upper_c   = relu_c[ACC_WIDTH-1:OUTPUT_WIDTH-1];
    fits_c    = (&upper_c) | ~(|upper_c);
    sat_val_c = relu_c[ACC_WIDTH-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge conv_filt_clk) begin
    if (conv_filt_rst) begin
      out_valid_o           <= 1'b0;
      conv_compute_filter_o <= '0;
      sat_o                 <= 1'b0;
    end else if (!stall) begin
      if (s3_valid) begin
        out_valid_o           <= 1'b1;
        conv_compute_filter_o <= fits_c ? relu_c[OUTPUT_WIDTH-1:0] : sat_val_c;
        sat_o                 <= ~fits_c;
      end else begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
